// File: rtl/cdf_lut_builder.sv
// cdf_lut_builder: sweeps the 256 histogram bins, accumulates the CDF,
// computes one equalization LUT entry per bin with an 8-step restoring
// divider, stores it in a 256x8 LUT RAM, and then maps streamed pixels
// through that LUT with one cycle of latency.
//
// Handshake: the pixel stream is a plain valid qualifier. A pixel is taken
// on any rising edge where map_valid_in && lut_ready. The result appears
// with map_valid_out exactly one cycle later. There is no backpressure.
module cdf_lut_builder #(
    parameter int HIST_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cdf_start,
    input  logic [HIST_W-1:0] total_pixels,
    input  logic [HIST_W-1:0] hist_data_in,
    output logic [7:0]        lut_k_addr,
    output logic              cdf_busy,
    output logic              cdf_done,
    output logic              lut_ready,
    input  logic              map_valid_in,
    input  logic [7:0]        map_pixel_in,
    output logic              map_valid_out,
    output logic [7:0]        map_pixel_out
);

    localparam int NUM_W = HIST_W + 8;

    // Every bin takes the same path: FETCH, READ, PREP, 8 x DIV, WRITE = 12 cycles.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_READ  = 3'd2,
        S_PREP  = 3'd3,
        S_DIV   = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        k_q, k_d;
    logic [HIST_W-1:0] t_q, t_d;
    logic [HIST_W-1:0] cdf_q, cdf_d;
    logic [HIST_W-1:0] cdf_min_q, cdf_min_d;
    logic [HIST_W-1:0] den_q, den_d;
    logic              found_q, found_d;
    logic [NUM_W-1:0]  rem_q, rem_d;
    logic [7:0]        quo_q, quo_d;
    logic [2:0]        div_cnt_q, div_cnt_d;
    logic              lut_ready_q, lut_ready_d;
    logic              map_valid_out_q;
    logic [7:0]        map_pixel_out_q;

    logic              lut_we;
    logic [7:0]        lut_wdata;
    logic [HIST_W-1:0] cdf_sum;
    logic [NUM_W-1:0]  numerator;
    logic [NUM_W-1:0]  div_sub;

    logic [7:0]        lut_mem [256];

    // Datapath helpers shared by the next-state logic.
    assign cdf_sum   = cdf_q + hist_data_in;
    assign numerator = NUM_W'(cdf_q - cdf_min_q) * NUM_W'(255) + NUM_W'(den_q >> 1);
    assign div_sub   = NUM_W'(den_q) << div_cnt_q;

    // Build FSM state and datapath registers; reset leaves the LUT RAM alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= 8'd0;
            t_q         <= '0;
            cdf_q       <= '0;
            cdf_min_q   <= '0;
            den_q       <= '0;
            found_q     <= 1'b0;
            rem_q       <= '0;
            quo_q       <= 8'd0;
            div_cnt_q   <= 3'd0;
            lut_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            cdf_q       <= cdf_d;
            cdf_min_q   <= cdf_min_d;
            den_q       <= den_d;
            found_q     <= found_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_cnt_q   <= div_cnt_d;
            lut_ready_q <= lut_ready_d;
        end
    end

    // Next-state logic for the per-bin sweep and the restoring divider.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        t_d         = t_q;
        cdf_d       = cdf_q;
        cdf_min_d   = cdf_min_q;
        den_d       = den_q;
        found_d     = found_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_cnt_d   = div_cnt_q;
        lut_ready_d = lut_ready_q;
        lut_we      = 1'b0;
        lut_wdata   = quo_q;

        case (state_q)
            S_IDLE: begin
                if (cdf_start) begin
                    state_d     = S_FETCH;
                    t_d         = total_pixels;
                    k_d         = 8'd0;
                    cdf_d       = '0;
                    cdf_min_d   = '0;
                    den_d       = '0;
                    found_d     = 1'b0;
                    lut_ready_d = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_READ;
            end
            S_READ: begin
                cdf_d = cdf_sum;
                if (!found_q && (hist_data_in != '0)) begin
                    found_d   = 1'b1;
                    cdf_min_d = cdf_sum;
                    den_d     = t_q - cdf_sum;
                end
                state_d = S_PREP;
            end
            S_PREP: begin
                // Quotient is below 256, so the divisor only needs shifts 7..0.
                rem_d     = numerator;
                quo_d     = 8'd0;
                div_cnt_d = 3'd7;
                state_d   = S_DIV;
            end
            S_DIV: begin
                if (rem_q >= div_sub) begin
                    rem_d = rem_q - div_sub;
                    quo_d = {quo_q[6:0], 1'b1};
                end else begin
                    quo_d = {quo_q[6:0], 1'b0};
                end
                div_cnt_d = div_cnt_q - 3'd1;
                if (div_cnt_q == 3'd0) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                lut_we = 1'b1;
                if (!found_q) begin
                    lut_wdata = 8'd0;
                end else if (den_q == '0) begin
                    lut_wdata = 8'd255;
                end else begin
                    lut_wdata = quo_q;
                end
                k_d = k_q + 8'd1;
                if (k_q == 8'd255) begin
                    state_d     = S_DONE;
                    lut_ready_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // LUT RAM write port, used only by the build sweep.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[k_q] <= lut_wdata;
        end
    end

    // LUT RAM read port: one-cycle pixel mapping, gated by lut_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_valid_out_q <= 1'b0;
            map_pixel_out_q <= 8'd0;
        end else if (map_valid_in && lut_ready_q) begin
            map_valid_out_q <= 1'b1;
            map_pixel_out_q <= lut_mem[map_pixel_in];
        end else begin
            map_valid_out_q <= 1'b0;
        end
    end

    assign lut_k_addr    = k_q;
    assign cdf_busy      = (state_q != S_IDLE);
    assign cdf_done      = (state_q == S_DONE);
    assign lut_ready     = lut_ready_q;
    assign map_valid_out = map_valid_out_q;
    assign map_pixel_out = map_pixel_out_q;

endmodule

// File: tb/tb_cdf_lut_builder.sv
// Directed bench for cdf_lut_builder: builds LUTs from hand-chosen
// histograms, streams every grey level through the map port and compares
// against hand-computed LUT contents and build timing.
module tb_cdf_lut_builder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cdf_start;
    logic [31:0] total_pixels;
    logic [31:0] hist_data_in;
    logic [7:0]  lut_k_addr;
    logic        cdf_busy;
    logic        cdf_done;
    logic        lut_ready;
    logic        map_valid_in;
    logic [7:0]  map_pixel_in;
    logic        map_valid_out;
    logic [7:0]  map_pixel_out;

    logic [31:0] hist [256];
    logic [7:0]  exp_lut [256];
    int          total = 0;
    int          bad = 0;

    // Clock generation.
    always #5 clk = ~clk;

    // Histogram read port model: data follows the held bin address.
    assign hist_data_in = hist[lut_k_addr];

    cdf_lut_builder #(.HIST_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cdf_start     (cdf_start),
        .total_pixels  (total_pixels),
        .hist_data_in  (hist_data_in),
        .lut_k_addr    (lut_k_addr),
        .cdf_busy      (cdf_busy),
        .cdf_done      (cdf_done),
        .lut_ready     (lut_ready),
        .map_valid_in  (map_valid_in),
        .map_pixel_in  (map_pixel_in),
        .map_valid_out (map_valid_out),
        .map_pixel_out (map_pixel_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 256; i++) hist[i] = 32'd0;
    endtask

    // Pulse cdf_start; returns at the negedge of cycle 1.
    task automatic start_build(input logic [31:0] t);
        @(negedge clk);
        total_pixels = t;
        cdf_start    = 1'b1;
        @(negedge clk);
        cdf_start    = 1'b0;
    endtask

    // Wait for cdf_done and check its timing; extra adds mid-build disturbances.
    task automatic wait_done(input bit extra);
        int cyc;
        bit seen;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 4000) begin
            if (cdf_done) begin
                seen = 1'b1;
            end else begin
                if (cyc == 1) begin
                    check("busy_c1", {31'd0, cdf_busy}, 32'd1);
                    check("ready_c1", {31'd0, lut_ready}, 32'd0);
                end
                if (cyc == 12) check("addr_c12", {24'd0, lut_k_addr}, 32'd0);
                if (cyc == 13) check("addr_c13", {24'd0, lut_k_addr}, 32'd1);
                if (extra) begin
                    if (cyc == 499) begin
                        total_pixels = 32'd0;
                        cdf_start    = 1'b1;
                    end
                    if (cyc == 500) cdf_start = 1'b0;
                    if (cyc == 1000) begin
                        map_valid_in = 1'b1;
                        map_pixel_in = 8'd7;
                    end
                    if (cyc == 1001 || cyc == 1002)
                        check("map_in_build", {31'd0, map_valid_out}, 32'd0);
                    if (cyc == 1002) map_valid_in = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_cycle", cyc, 32'd3073);
            check("busy_at_done", {31'd0, cdf_busy}, 32'd1);
            check("ready_at_done", {31'd0, lut_ready}, 32'd1);
            @(negedge clk);
            check("done_pulse", {31'd0, cdf_done}, 32'd0);
            check("busy_after", {31'd0, cdf_busy}, 32'd0);
            check("ready_after", {31'd0, lut_ready}, 32'd1);
            check("addr_after", {24'd0, lut_k_addr}, 32'd0);
        end
    endtask

    // Stream all 256 grey levels back-to-back and compare against exp_lut.
    task automatic stream_all(input string name);
        for (int i = 0; i < 256; i++) begin
            map_valid_in = 1'b1;
            map_pixel_in = 8'(i);
            @(negedge clk);
            check($sformatf("%s_vld[%0d]", name, i), {31'd0, map_valid_out}, 32'd1);
            check($sformatf("%s_lut[%0d]", name, i), {24'd0, map_pixel_out}, {24'd0, exp_lut[i]});
        end
        map_valid_in = 1'b0;
        @(negedge clk);
        check({name, "_vld_end"}, {31'd0, map_valid_out}, 32'd0);
    endtask

    initial begin
        logic [7:0] pix_seq [3];
        logic [7:0] out_seq [3];

        reset_n      = 1'b0;
        cdf_start    = 1'b0;
        total_pixels = 32'd0;
        map_valid_in = 1'b0;
        map_pixel_in = 8'd0;
        clear_hist();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_addr", {24'd0, lut_k_addr}, 32'd0);
        check("rst_busy", {31'd0, cdf_busy}, 32'd0);
        check("rst_done", {31'd0, cdf_done}, 32'd0);
        check("rst_ready", {31'd0, lut_ready}, 32'd0);
        check("rst_mvld", {31'd0, map_valid_out}, 32'd0);
        check("rst_mpix", {24'd0, map_pixel_out}, 32'd0);
        reset_n = 1'b1;

        // Mapping before any build is ignored.
        @(negedge clk);
        map_valid_in = 1'b1;
        map_pixel_in = 8'd3;
        @(negedge clk);
        check("map_not_ready", {31'd0, map_valid_out}, 32'd0);
        map_valid_in = 1'b0;

        // Uniform histogram: identity LUT.
        for (int i = 0; i < 256; i++) begin
            hist[i]    = 32'd1;
            exp_lut[i] = 8'(i);
        end
        start_build(32'd256);
        wait_done(1'b0);
        stream_all("uni");

        // Two spikes at 10 and 200.
        clear_hist();
        hist[10]  = 32'd100;
        hist[200] = 32'd100;
        for (int i = 0; i < 256; i++) exp_lut[i] = (i < 200) ? 8'd0 : 8'd255;
        start_build(32'd200);
        wait_done(1'b0);
        stream_all("spk");
        pix_seq[0] = 8'd10;  out_seq[0] = 8'd0;
        pix_seq[1] = 8'd200; out_seq[1] = 8'd255;
        pix_seq[2] = 8'd5;   out_seq[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            map_valid_in = 1'b1;
            map_pixel_in = pix_seq[i];
            @(negedge clk);
            check($sformatf("seq_vld%0d", i), {31'd0, map_valid_out}, 32'd1);
            check($sformatf("seq_pix%0d", i), {24'd0, map_pixel_out}, {24'd0, out_seq[i]});
        end
        map_valid_in = 1'b0;
        @(negedge clk);
        check("seq_vld_end", {31'd0, map_valid_out}, 32'd0);

        // Rounding: h0=1 h1=2, T=3.
        clear_hist();
        hist[0] = 32'd1;
        hist[1] = 32'd2;
        for (int i = 0; i < 256; i++) exp_lut[i] = (i == 0) ? 8'd0 : 8'd255;
        start_build(32'd3);
        wait_done(1'b0);
        stream_all("rnd_a");

        // Rounding: h0=h1=h2=1, T=3 -> 0, 128, 255...
        clear_hist();
        hist[0] = 32'd1;
        hist[1] = 32'd1;
        hist[2] = 32'd1;
        for (int i = 0; i < 256; i++) exp_lut[i] = 8'd255;
        exp_lut[0] = 8'd0;
        exp_lut[1] = 8'd128;
        start_build(32'd3);
        wait_done(1'b0);
        stream_all("rnd_b");

        // Single-valued image: den = 0.
        clear_hist();
        hist[50] = 32'd64;
        for (int i = 0; i < 256; i++) exp_lut[i] = (i < 50) ? 8'd0 : 8'd255;
        start_build(32'd64);
        wait_done(1'b0);
        stream_all("single");

        // Empty histogram, T = 0.
        clear_hist();
        for (int i = 0; i < 256; i++) exp_lut[i] = 8'd0;
        start_build(32'd0);
        wait_done(1'b0);
        stream_all("empty");

        // Reset in the middle of a uniform build.
        for (int i = 0; i < 256; i++) begin
            hist[i]    = 32'd1;
            exp_lut[i] = 8'(i);
        end
        start_build(32'd256);
        begin
            int n;
            n = 0;
            while (lut_k_addr != 8'd100 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("reach_addr100", {24'd0, lut_k_addr}, 32'd100);
        end
        reset_n = 1'b0;
        #1;
        check("mrst_busy", {31'd0, cdf_busy}, 32'd0);
        check("mrst_ready", {31'd0, lut_ready}, 32'd0);
        check("mrst_done", {31'd0, cdf_done}, 32'd0);
        check("mrst_addr", {24'd0, lut_k_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Rebuild with a stray start at cycle 500 and mapping attempts mid-build.
        start_build(32'd256);
        wait_done(1'b1);
        stream_all("rerun");

        // Valid follows input with one cycle delay, including gaps.
        map_valid_in = 1'b1;
        map_pixel_in = 8'd42;
        @(negedge clk);
        check("gap_v1", {31'd0, map_valid_out}, 32'd1);
        check("gap_p1", {24'd0, map_pixel_out}, 32'd42);
        map_valid_in = 1'b0;
        @(negedge clk);
        check("gap_v2", {31'd0, map_valid_out}, 32'd0);
        map_valid_in = 1'b1;
        map_pixel_in = 8'd255;
        @(negedge clk);
        check("gap_v3", {31'd0, map_valid_out}, 32'd1);
        check("gap_p3", {24'd0, map_pixel_out}, 32'd255);
        map_valid_in = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdf_lut_builder.md
# cdf_lut_builder

Downstream neighbour of the histogram accumulator. After pass 1 completes, it sweeps the 256 histogram bins through the accumulator's sequential read port and accumulates the CDF. It computes the equalization LUT entry for each grey level with a small sequential divider and stores the result in an internal 256×8 LUT RAM. In pass 2 it maps a streamed pixel to its equalized value with one-cycle latency.

## Interface
- HIST_W, 32: width of histogram counts, `total_pixels` and the internal CDF.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cdf_start  in  1  one-cycle pulse that starts a LUT build; only accepted in IDLE.
- total_pixels  in  HIST_W  pixel count T from the accumulator; sampled on the `cdf_start` edge.
- hist_data_in  in  HIST_W  histogram count; valid one cycle after `lut_k_addr` is presented.
- lut_k_addr  out  8  histogram read address.
- cdf_busy  out  1  high while a build is in progress.
- cdf_done  out  1  one-cycle pulse when the LUT is complete.
- lut_ready  out  1  high from `cdf_done` until the next accepted `cdf_start` or reset.
- map_valid_in  in  1  pixel-stream valid.
- map_pixel_in  in  8  pixel to equalize.
- map_valid_out  out  1  registered valid.
- map_pixel_out  out  8  equalized pixel.

## Operation
- Reset values: `lut_k_addr`=0, `cdf_busy`=0, `cdf_done`=0, `lut_ready`=0, `map_valid_out`=0, `map_pixel_out`=0. The FSM returns to IDLE. Reset does not clear LUT RAM contents.
- FSM states: IDLE → FETCH → READ → PREP → DIV (8 cycles) → WRITE → FETCH for the next bin. WRITE of bin 255 goes to DONE, and DONE goes to IDLE.
- IDLE: on `cdf_start`, latch T, set k=0, clear cdf and the cdf_min-found flag, and clear `lut_ready`.
- FETCH: drive `lut_k_addr`=k. The address is held at k for every state of that bin.
- READ: `hist_data_in` = h[k]. Set cdf += h[k] (HIST_W wide, no overflow because cdf ≤ T). On the first bin with h[k]≠0, set cdf_min = the new cdf and den = T − cdf_min.
- PREP:
  - Numerator = (cdf − cdf_min)·255 + floor(den/2), 40 bits wide.
  - Load the restoring divider; the quotient is provably < 256, so 8 iterations suffice.
- DIV: one quotient bit per cycle, MSB first.
- WRITE: write LUT[k] using these rules, in priority order:
  - 0 if cdf_min is not yet found (including T=0).
  - 255 if den=0 (single-valued image).
  - Otherwise the quotient.
  - Then increment k; 255 wraps to 0 on exit.
- DONE: pulse `cdf_done`, set `lut_ready`, drop `cdf_busy`.
- `cdf_start` while not in IDLE is ignored.
- Mapping, when `map_valid_in` && `lut_ready`:
  - Next cycle, `map_pixel_out` = LUT[`map_pixel_in`] and `map_valid_out`=1.
  - Back-to-back pixels are accepted every cycle.
  - When `lut_ready`=0, `map_valid_in` is ignored and `map_valid_out` stays 0.
- The LUT RAM has one synchronous write port (build) and one synchronous read port (map). They are never active simultaneously.

## Timing
- Every bin takes exactly 12 cycles, regardless of data.
- Relative to the edge that samples `cdf_start` (cycle 0):
  - `cdf_busy` is high in cycles 1–3073.
  - `lut_k_addr`=k in cycles 1+12k … 12+12k.
  - `cdf_done` is high in cycle 3073 only.
  - `lut_ready` rises in cycle 3073.
- Mapping latency is 1 cycle; throughput is 1 pixel per cycle.
- Reset mid-build: all outputs return immediately to their reset values, no `cdf_done` is issued, and a new `cdf_start` performs a full correct build.
- The upstream accumulator must have `hist_start` low for the whole build, so that its read port is active.

## Test plan
- Uniform histogram, h[k]=1 for all k, T=256: cdf_min=1 and den=255, giving LUT[k]=k for all k. `cdf_done` occurs exactly 3073 cycles after `cdf_start`.
- h[10]=100, h[200]=100, T=200: LUT[0..199]=0 and LUT[200..255]=255. Stream 10, 200, 5 on consecutive cycles → outputs 0, 255, 0, each one cycle later.
- h[0]=1, h[1]=2, T=3: LUT[0]=0 and LUT[1..255]=255 (rounding check: (2·255+1)/2 = 255). h[0]=1, h[1]=1, h[2]=1, T=3: LUT[1]=128 and LUT[2]=255.
- Single value h[50]=64, T=64 (den=0): LUT[0..49]=0 and LUT[50..255]=255. All-zero histogram with T=0: all 256 entries are 0, and `cdf_done` still fires at cycle 3073.
- Assert `reset_n` low while `lut_k_addr`=100: `cdf_busy`, `lut_ready` and `cdf_done` go to 0 immediately, and `lut_k_addr`=0. Re-run the uniform case → identity LUT.
- A second `cdf_start` in cycle 500 is ignored, with the done timing unchanged. `map_valid_in` during the build gives `map_valid_out`=0. After `cdf_done`, `map_valid_out` follows `map_valid_in` delayed by one cycle.
